// File: rtl/arcade_input_mapper.sv
// rtl/arcade_input_mapper.sv - per-player joystick debounce, direction lockout and coin pulse shaping
// Source select, per-bit debounce, registered outputs and a one-shot coin FSM per player.
module arcade_input_mapper #(
  parameter int PLAYERS  = 2,
  parameter int BUTTONS  = 2,
  parameter int DEBOUNCE = 4,
  parameter int COIN_HI  = 8,
  parameter int COIN_LO  = 8,
  parameter int LOCKOUT  = 1
) (
  input  logic                         clk_sys,
  input  logic                         reset_n,
  input  logic                         ce,
  input  logic [PLAYERS*16-1:0]        joy_in,
  input  logic                         shared,
  output logic [PLAYERS*4-1:0]         dir_out,
  output logic [PLAYERS*BUTTONS-1:0]   btn_out,
  output logic [PLAYERS-1:0]           start_out,
  output logic [PLAYERS-1:0]           coin_out
);

  localparam int NB      = 6 + BUTTONS;
  localparam int B_START = 4 + BUTTONS;
  localparam int B_COIN  = 5 + BUTTONS;
  localparam int DCW     = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;
  localparam logic [DCW-1:0] DB_LAST = DCW'((DEBOUNCE > 0) ? DEBOUNCE - 1 : 0);
  localparam int CMAX    = (COIN_HI > COIN_LO) ? COIN_HI : COIN_LO;
  localparam int CCW     = $clog2(CMAX + 1);
  localparam logic [CCW-1:0] HI_LAST = CCW'(COIN_HI - 1);
  localparam logic [CCW-1:0] LO_LAST = CCW'(COIN_LO - 1);
  localparam logic LK = (LOCKOUT != 0);

  typedef enum logic [1:0] {
    COIN_IDLE,
    COIN_HIGH,
    COIN_LOW,
    COIN_WAIT
  } coin_state_t;

  logic [NB-1:0]          w_or;
  logic [NB-1:0]          w_src      [PLAYERS];
  logic [NB-1:0]          r_db       [PLAYERS];
  logic [DCW-1:0]         r_db_cnt   [PLAYERS][NB];
  logic [PLAYERS*4-1:0]   w_dir;
  logic [PLAYERS*4-1:0]   r_dir;
  logic [PLAYERS*BUTTONS-1:0] r_btn;
  logic [PLAYERS-1:0]     r_start;
  coin_state_t            r_coin_st  [PLAYERS];
  coin_state_t            w_coin_st_nx [PLAYERS];
  logic [CCW-1:0]         r_coin_cnt [PLAYERS];
  logic [CCW-1:0]         w_coin_cnt_nx [PLAYERS];
  logic [PLAYERS-1:0]     w_coin;
  logic                   w_unused_joy;

  // Bits above the coin bit of each word carry nothing for this core.
  assign w_unused_joy = ^joy_in;

  always_comb begin
    w_or = '0;
    for (int p = 0; p < PLAYERS; p++) begin
      w_or = w_or | joy_in[16*p +: NB];
    end
    for (int p = 0; p < PLAYERS; p++) begin
      w_src[p] = shared ? w_or : joy_in[16*p +: NB];
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < PLAYERS; p++) begin
        r_db[p] <= '0;
        for (int b = 0; b < NB; b++) begin
          r_db_cnt[p][b] <= '0;
        end
      end
    end else if (ce) begin
      for (int p = 0; p < PLAYERS; p++) begin
        for (int b = 0; b < NB; b++) begin
          if (DEBOUNCE == 0) begin
            r_db[p][b] <= w_src[p][b];
          end else if (w_src[p][b] == r_db[p][b]) begin
            r_db_cnt[p][b] <= '0;
          end else if (r_db_cnt[p][b] == DB_LAST) begin
            r_db[p][b]     <= w_src[p][b];
            r_db_cnt[p][b] <= '0;
          end else begin
            r_db_cnt[p][b] <= r_db_cnt[p][b] + 1'b1;
          end
        end
      end
    end
  end

  // Opposing directions cancel each other before they reach the output register.
  always_comb begin
    w_dir = '0;
    for (int p = 0; p < PLAYERS; p++) begin
      w_dir[4*p+0] = r_db[p][0] & ~(LK & r_db[p][1]);
      w_dir[4*p+1] = r_db[p][1] & ~(LK & r_db[p][0]);
      w_dir[4*p+2] = r_db[p][2] & ~(LK & r_db[p][3]);
      w_dir[4*p+3] = r_db[p][3] & ~(LK & r_db[p][2]);
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_dir   <= '0;
      r_btn   <= '0;
      r_start <= '0;
    end else if (ce) begin
      r_dir <= w_dir;
      for (int p = 0; p < PLAYERS; p++) begin
        r_btn[BUTTONS*p +: BUTTONS] <= r_db[p][4 +: BUTTONS];
        r_start[p]                  <= r_db[p][B_START];
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < PLAYERS; p++) begin
        r_coin_st[p]  <= COIN_IDLE;
        r_coin_cnt[p] <= '0;
      end
    end else if (ce) begin
      for (int p = 0; p < PLAYERS; p++) begin
        r_coin_st[p]  <= w_coin_st_nx[p];
        r_coin_cnt[p] <= w_coin_cnt_nx[p];
      end
    end
  end

  // WAIT holds off re-arming until the debounced coin has been seen released.
  always_comb begin
    w_coin = '0;
    for (int p = 0; p < PLAYERS; p++) begin
      w_coin_st_nx[p]  = r_coin_st[p];
      w_coin_cnt_nx[p] = r_coin_cnt[p];
      case (r_coin_st[p])
        COIN_IDLE: begin
          if (r_db[p][B_COIN]) begin
            w_coin_st_nx[p]  = COIN_HIGH;
            w_coin_cnt_nx[p] = '0;
          end
        end
        COIN_HIGH: begin
          w_coin[p] = 1'b1;
          if (r_coin_cnt[p] == HI_LAST) begin
            w_coin_st_nx[p]  = COIN_LOW;
            w_coin_cnt_nx[p] = '0;
          end else begin
            w_coin_cnt_nx[p] = r_coin_cnt[p] + 1'b1;
          end
        end
        COIN_LOW: begin
          if (r_coin_cnt[p] == LO_LAST) begin
            w_coin_st_nx[p]  = COIN_WAIT;
            w_coin_cnt_nx[p] = '0;
          end else begin
            w_coin_cnt_nx[p] = r_coin_cnt[p] + 1'b1;
          end
        end
        COIN_WAIT: begin
          if (!r_db[p][B_COIN]) begin
            w_coin_st_nx[p] = COIN_IDLE;
          end
        end
        default: begin
          w_coin_st_nx[p]  = COIN_IDLE;
          w_coin_cnt_nx[p] = '0;
        end
      endcase
    end
  end

  assign dir_out   = r_dir;
  assign btn_out   = r_btn;
  assign start_out = r_start;
  assign coin_out  = w_coin;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// tb/tb_arcade_input_mapper.sv - scoreboard bench for two arcade_input_mapper configurations
// A sample-window/timestamp model predicts outputs; a monitor pops and compares each clock.
module tb_arcade_input_mapper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        ce;
  logic        shared;
  logic [63:0] joy;

  logic [7:0]  a_dir;
  logic [3:0]  a_btn;
  logic [1:0]  a_start;
  logic [1:0]  a_coin;
  logic [11:0] b_dir;
  logic [8:0]  b_btn;
  logic [2:0]  b_start;
  logic [2:0]  b_coin;

  arcade_input_mapper #(
    .PLAYERS(2), .BUTTONS(2), .DEBOUNCE(4), .COIN_HI(8), .COIN_LO(8), .LOCKOUT(1)
  ) u_a (
    .clk_sys(clk), .reset_n(reset_n), .ce(ce), .joy_in(joy[31:0]), .shared(shared),
    .dir_out(a_dir), .btn_out(a_btn), .start_out(a_start), .coin_out(a_coin)
  );

  arcade_input_mapper #(
    .PLAYERS(3), .BUTTONS(3), .DEBOUNCE(2), .COIN_HI(3), .COIN_LO(5), .LOCKOUT(0)
  ) u_b (
    .clk_sys(clk), .reset_n(reset_n), .ce(ce), .joy_in(joy[47:0]), .shared(shared),
    .dir_out(b_dir), .btn_out(b_btn), .start_out(b_start), .coin_out(b_coin)
  );

  typedef struct packed {
    logic [15:0] dir;
    logic [39:0] btn;
    logic [3:0]  st;
    logic [3:0]  coin;
  } exp_t;

  int total = 0;
  int bad   = 0;

  logic m_db   [2][4][16];
  logic m_last [2][4][16];
  int   m_run  [2][4][16];
  logic m_armed  [2][4];
  int   m_cstart [2][4];
  int   m_n;
  exp_t m_cur [2];
  exp_t q_a [$];
  exp_t q_b [$];

  function automatic int npl(int i);  return (i == 0) ? 2 : 3; endfunction
  function automatic int nbut(int i); return (i == 0) ? 2 : 3; endfunction
  function automatic int ndb(int i);  return (i == 0) ? 4 : 2; endfunction
  function automatic int chi(int i);  return (i == 0) ? 8 : 3; endfunction
  function automatic int clo(int i);  return (i == 0) ? 8 : 5; endfunction
  function automatic bit lck(int i);  return (i == 0); endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 4; p++) begin
        m_armed[i][p]  = 1'b1;
        m_cstart[i][p] = 0;
        for (int b = 0; b < 16; b++) begin
          m_db[i][p][b]   = 1'b0;
          m_last[i][p][b] = 1'b0;
          m_run[i][p][b]  = 0;
        end
      end
      m_cur[i] = '0;
    end
  endtask

  // One ce tick: outputs follow the pre-tick debounced state; a bit flips once its
  // newest ndb samples all agree on the new value.
  task automatic model_tick(input logic [63:0] j, input logic sh);
    m_n++;
    for (int i = 0; i < 2; i++) begin
      int   np;
      int   nb;
      int   bt;
      exp_t e;
      logic r, l, d, u, s, cn;
      np = npl(i);
      bt = nbut(i);
      nb = 6 + bt;
      e  = '0;
      for (int p = 0; p < np; p++) begin
        r = m_db[i][p][0];
        l = m_db[i][p][1];
        d = m_db[i][p][2];
        u = m_db[i][p][3];
        if (lck(i)) begin
          if (r && l) begin r = 1'b0; l = 1'b0; end
          if (u && d) begin u = 1'b0; d = 1'b0; end
        end
        e.dir[4*p +: 4] = {u, d, l, r};
        for (int k = 0; k < bt; k++) e.btn[bt*p + k] = m_db[i][p][4+k];
        e.st[p] = m_db[i][p][4+bt];
        cn = m_db[i][p][5+bt];
        if (m_armed[i][p]) begin
          if (cn) begin
            m_armed[i][p]  = 1'b0;
            m_cstart[i][p] = m_n;
          end
        end else if (m_n >= m_cstart[i][p] + chi(i) + clo(i) + 1 && !cn) begin
          m_armed[i][p] = 1'b1;
        end
        e.coin[p] = !m_armed[i][p] && (m_n - m_cstart[i][p] < chi(i));
        for (int b = 0; b < nb; b++) begin
          s = 1'b0;
          if (sh) begin
            for (int q = 0; q < np; q++) s = s | j[16*q + b];
          end else begin
            s = j[16*p + b];
          end
          if (s == m_last[i][p][b]) m_run[i][p][b]++;
          else begin
            m_last[i][p][b] = s;
            m_run[i][p][b]  = 1;
          end
          if (s != m_db[i][p][b] && m_run[i][p][b] >= ndb(i)) m_db[i][p][b] = s;
        end
      end
      m_cur[i] = e;
    end
  endtask

  task automatic cycle(input logic [63:0] j, input logic c, input logic sh, input logic rn);
    @(negedge clk);
    joy     = j;
    ce      = c;
    shared  = sh;
    reset_n = rn;
    if (!rn) model_reset();
    else if (c) model_tick(j, sh);
    q_a.push_back(m_cur[0]);
    q_b.push_back(m_cur[1]);
  endtask

  initial begin
    exp_t ea;
    exp_t eb;
    forever begin
      @(posedge clk);
      #1;
      if (q_a.size() > 0 && q_b.size() > 0) begin
        ea = q_a.pop_front();
        eb = q_b.pop_front();
        chk("a_dir",   a_dir,   ea.dir[7:0]);
        chk("a_btn",   a_btn,   ea.btn[3:0]);
        chk("a_start", a_start, ea.st[1:0]);
        chk("a_coin",  a_coin,  ea.coin[1:0]);
        chk("b_dir",   b_dir,   eb.dir[11:0]);
        chk("b_btn",   b_btn,   eb.btn[8:0]);
        chk("b_start", b_start, eb.st[2:0]);
        chk("b_coin",  b_coin,  eb.coin[2:0]);
      end
    end
  end

  initial begin
    logic [63:0] j;
    logic        sh;
    logic        found;
    reset_n = 1'b0;
    ce      = 1'b0;
    shared  = 1'b0;
    joy     = '0;
    m_n     = 0;
    model_reset();
    repeat (3) cycle(64'h0, 1'b1, 1'b0, 1'b0);

    // short glitch, then a held press on P1 right
    repeat (8)  cycle(64'h0, 1'b1, 1'b0, 1'b1);
    repeat (3)  cycle(64'h1, 1'b1, 1'b0, 1'b1);
    repeat (8)  cycle(64'h0, 1'b1, 1'b0, 1'b1);
    repeat (10) cycle(64'h1, 1'b1, 1'b0, 1'b1);
    repeat (8)  cycle(64'h0, 1'b1, 1'b0, 1'b1);

    // left+right together, then right released
    repeat (20) cycle(64'h3, 1'b1, 1'b0, 1'b1);
    repeat (10) cycle(64'h2, 1'b1, 1'b0, 1'b1);
    repeat (8)  cycle(64'hC, 1'b1, 1'b0, 1'b1);
    repeat (8)  cycle(64'h0, 1'b1, 1'b0, 1'b1);

    // P2 button0 in shared and private mode
    repeat (10) cycle(64'h0010_0000, 1'b1, 1'b1, 1'b1);
    repeat (10) cycle(64'h0010_0000, 1'b1, 1'b0, 1'b1);
    repeat (10) cycle(64'h0, 1'b1, 1'b0, 1'b1);

    // P2 coin held long, released, pressed again
    repeat (100) cycle(64'h0180_0000, 1'b1, 1'b0, 1'b1);
    repeat (30)  cycle(64'h0, 1'b1, 1'b0, 1'b1);
    repeat (40)  cycle(64'h0180_0000, 1'b1, 1'b0, 1'b1);
    repeat (30)  cycle(64'h0, 1'b1, 1'b0, 1'b1);

    // reset asserted while the coin pulse is high
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      cycle(64'h0080_0000, 1'b1, 1'b0, 1'b1);
      if (a_coin[1]) found = 1'b1;
    end
    chk("coin_rise_timeout", {63'd0, found}, 64'd1);
    if (found) begin
      cycle(64'h0080_0000, 1'b1, 1'b0, 1'b0);
      #1;
      chk("coin_async_reset", {62'd0, a_coin}, 64'd0);
    end
    repeat (2)  cycle(64'h0080_0000, 1'b1, 1'b0, 1'b0);
    repeat (40) cycle(64'h0080_0000, 1'b1, 1'b0, 1'b1);
    repeat (20) cycle(64'h0, 1'b1, 1'b0, 1'b1);

    // sparse ce strobes with a start press
    for (int k = 0; k < 240; k++) begin
      j = (k < 120) ? 64'h0000_0000_00C0 : 64'h0;
      cycle(j, (k % 8) == 0, 1'b0, 1'b1);
    end

    // randomized traffic with occasional shared toggles and resets
    j  = '0;
    sh = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      for (int b = 0; b < 48; b++) begin
        if ($urandom_range(0, 15) == 0) j[b] = ~j[b];
      end
      if ($urandom_range(0, 149) == 0) sh = ~sh;
      cycle(j, $urandom_range(0, 3) != 0, sh, $urandom_range(0, 399) != 0);
    end

    repeat (3) @(negedge clk);
    chk("queue_drain", 64'(q_a.size() + q_b.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
